// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a direct-mapped BTB/BHT. The fetch stage reads a prediction
// combinationally; the execute stage resolves against it and trains the table on the following edge.
module branch_predict_unit #(
  parameter int WIDTH    = 9,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [1:0]       ctrl_transfer,
  input  logic [31:0]      imm,
  input  logic [31:0]      ALU_result,
  input  logic             halt,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic [31:0]      branch_pc,
  output logic [31:0]      pc_plus_4,
  output logic             pc_sel,
  output logic [31:0]      mispred_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  localparam logic [1:0] CT_NONE   = 2'b00;
  localparam logic [1:0] CT_BRANCH = 2'b01;
  localparam logic [1:0] CT_JAL    = 2'b10;
  localparam logic [1:0] CT_JALR   = 2'b11;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic                jump_q   [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
  logic [31:0]         mispred_cnt_q;

  // Fetch-side lookup; the low two PC bits never select an entry.
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             if_pc_unused;

  assign if_idx       = if_pc[IDX+1:2];
  assign if_tag       = if_pc[WIDTH-1:IDX+2];
  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken   = if_hit && (jump_q[if_idx] || cnt_q[if_idx][CNT_BITS-1]);
  assign pred_target  = pred_taken ? target_q[if_idx] : 32'h0;
  assign if_pc_unused = ^if_pc[1:0];

  logic [31:0] pc32;
  logic [31:0] res_target;
  logic        act_taken;
  logic        mispredict;

  assign pc32      = {{(32-WIDTH){1'b0}}, ex_pc};
  assign pc_plus_4 = pc32 + 32'd4;

  always_comb begin
    act_taken  = 1'b0;
    res_target = pc32 + imm;
    case (ctrl_transfer)
      CT_BRANCH: act_taken = ALU_result[0];
      CT_JAL:    act_taken = 1'b1;
      CT_JALR: begin
        act_taken  = 1'b1;
        res_target = (pc32 + ALU_result) & 32'hFFFF_FFFE;
      end
      default:   act_taken = 1'b0;
    endcase
  end

  assign mispredict = ex_valid &&
                      ((act_taken != ex_pred_taken) ||
                       (act_taken && (res_target != ex_pred_target)));

  always_comb begin
    pc_sel    = 1'b0;
    branch_pc = pc_plus_4;
    if (halt) begin
      pc_sel    = 1'b1;
      branch_pc = 32'hFFFF_FFFF;
    end else if (mispredict) begin
      pc_sel    = 1'b1;
      branch_pc = act_taken ? res_target : pc_plus_4;
    end
  end

  // Training for the resolved instruction's entry.
  logic [IDX-1:0]      ex_idx;
  logic [TAG_W-1:0]    ex_tag;
  logic                ex_hit;
  logic                wr_en;
  logic                clr_en;
  logic [CNT_BITS-1:0] cnt_d;

  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[WIDTH-1:IDX+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign wr_en  = ex_valid && !halt && (ctrl_transfer != CT_NONE);
  assign clr_en = ex_valid && !halt && (ctrl_transfer == CT_NONE) && ex_pred_taken;

  always_comb begin
    cnt_d = act_taken ? CNT_WT : CNT_WNT;
    if (ex_hit) begin
      if (act_taken) cnt_d = (cnt_q[ex_idx] == CNT_MAX) ? CNT_MAX : cnt_q[ex_idx] + CNT_BITS'(1);
      else           cnt_d = (cnt_q[ex_idx] == '0) ? '0 : cnt_q[ex_idx] - CNT_BITS'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[gi]  <= 1'b0;
          tag_q[gi]    <= '0;
          target_q[gi] <= 32'h0;
          jump_q[gi]   <= 1'b0;
          cnt_q[gi]    <= CNT_WNT;
        end else if (wr_en && (ex_idx == IDX'(gi))) begin
          valid_q[gi] <= 1'b1;
          tag_q[gi]   <= ex_tag;
          jump_q[gi]  <= ctrl_transfer[1];
          cnt_q[gi]   <= cnt_d;
          if (act_taken) target_q[gi] <= res_target;
        end else if (clr_en && (ex_idx == IDX'(gi))) begin
          valid_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt_q <= 32'h0;
    end else if (mispredict && !halt && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a table-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_branch_predict_unit;
  localparam int WIDTH = 9, ENTRIES = 16, CNT_BITS = 2;
  localparam int HALF = 1 << (CNT_BITS - 1);
  localparam int CMAX = (1 << CNT_BITS) - 1;

  logic             clk, rst_n;
  logic [WIDTH-1:0] if_pc, ex_pc;
  logic             pred_taken, ex_valid, halt, ex_pred_taken, pc_sel;
  logic [31:0]      pred_target, imm, ALU_result, ex_pred_target, branch_pc, pc_plus_4, mispred_cnt;
  logic [1:0]       ctrl_transfer;

  int n_cmp = 0;
  int n_err = 0;

  branch_predict_unit #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ctrl_transfer(ctrl_transfer), .imm(imm),
    .ALU_result(ALU_result), .halt(halt), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .branch_pc(branch_pc), .pc_plus_4(pc_plus_4),
    .pc_sel(pc_sel), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per entry, counters kept as plain integers.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_target[ENTRIES];
  bit          m_jump  [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_mcnt;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void resolve(output bit act, output logic [31:0] tgt);
    logic [31:0] pc = 32'(ex_pc);
    act = 1'b0;
    tgt = pc + imm;
    if (ctrl_transfer == 2'b01) act = ALU_result[0];
    if (ctrl_transfer == 2'b10) act = 1'b1;
    if (ctrl_transfer == 2'b11) begin
      act = 1'b1;
      tgt = (pc + ALU_result) & 32'hFFFF_FFFE;
    end
  endfunction

  function automatic bit is_mispred();
    bit act;
    logic [31:0] tgt;
    resolve(act, tgt);
    return ex_valid && ((act != ex_pred_taken) || (act && tgt != ex_pred_target));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_jump[i] = 0; m_cnt[i] = HALF - 1;
      end
      m_mcnt = 0;
    end else begin
      bit act;
      logic [31:0] tgt;
      int i, t;
      resolve(act, tgt);
      i = (int'(ex_pc) / 4) % ENTRIES;
      t = int'(ex_pc) / (4 * ENTRIES);
      if (is_mispred() && !halt && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
      if (ex_valid && !halt && ctrl_transfer != 2'b00) begin
        if (m_valid[i] && m_tag[i] == t)
          m_cnt[i] = act ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                         : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        else
          m_cnt[i] = act ? HALF : HALF - 1;
        m_valid[i] = 1;
        m_tag[i]   = t;
        m_jump[i]  = (ctrl_transfer != 2'b01);
        if (act) m_target[i] = tgt;
      end else if (ex_valid && !halt && ctrl_transfer == 2'b00 && ex_pred_taken) begin
        m_valid[i] = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit act, mis, ptk;
    logic [31:0] tgt, p4, bpc;
    int i, t;
    i = (int'(if_pc) / 4) % ENTRIES;
    t = int'(if_pc) / (4 * ENTRIES);
    ptk = m_valid[i] && m_tag[i] == t && (m_jump[i] || m_cnt[i] >= HALF);
    resolve(act, tgt);
    mis = is_mispred();
    p4  = 32'(ex_pc) + 32'd4;
    bpc = halt ? 32'hFFFF_FFFF : (mis && act) ? tgt : p4;
    check("model.pred_taken", 32'(pred_taken), 32'(ptk));
    check("model.pred_target", pred_target, ptk ? m_target[i] : 32'h0);
    check("model.pc_sel", 32'(pc_sel), 32'(halt || mis));
    check("model.branch_pc", branch_pc, bpc);
    check("model.pc_plus_4", pc_plus_4, p4);
    check("model.mispred_cnt", mispred_cnt, m_mcnt);
  end

  task automatic step(bit v, logic [8:0] pc, logic [1:0] ct, logic [31:0] im, logic [31:0] alu,
                      bit h, bit ept, logic [31:0] eptg, logic [8:0] ipc);
    @(posedge clk);
    #1;
    ex_valid = v; ex_pc = pc; ctrl_transfer = ct; imm = im; ALU_result = alu;
    halt = h; ex_pred_taken = ept; ex_pred_target = eptg; if_pc = ipc;
    $display("step v=%0d pc=%h ct=%0d imm=%h alu=%h halt=%0d ept=%0d eptg=%h if_pc=%h",
             v, pc, ct, im, alu, h, ept, eptg, ipc);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(logic [8:0] ipc);
    step(0, 9'h0, 2'b00, 0, 0, 0, 0, 0, ipc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_pc = 0; ctrl_transfer = 0; imm = 0; ALU_result = 0;
    halt = 0; ex_pred_taken = 0; ex_pred_target = 0; if_pc = 9'h010;
    repeat (2) @(negedge clk);
    #1;
    // T1 reset state
    check("T1.pred_taken", 32'(pred_taken), 0);
    check("T1.pred_target", pred_target, 0);
    check("T1.mispred_cnt", mispred_cnt, 0);
    rst_n = 1'b1;

    // T2 first taken branch trains the table
    step(1, 9'h010, 2'b01, 32'h20, 1, 0, 0, 0, 9'h010);
    check("T2.pc_sel", 32'(pc_sel), 1);
    check("T2.branch_pc", branch_pc, 32'h30);
    check("T2.pred_same_cycle", 32'(pred_taken), 0);
    idle(9'h010);
    check("T2.pred_taken", 32'(pred_taken), 1);
    check("T2.pred_target", pred_target, 32'h30);
    check("T2.mispred_cnt", mispred_cnt, 1);

    // T3 not-taken walk of the counter, saturation at zero
    step(1, 9'h010, 2'b01, 32'h20, 0, 0, 1, 32'h30, 9'h010);
    check("T3.pc_sel1", 32'(pc_sel), 1);
    check("T3.branch_pc1", branch_pc, 32'h14);
    step(1, 9'h010, 2'b01, 32'h20, 0, 0, 0, 0, 9'h010);
    check("T3.pred_after1", 32'(pred_taken), 0);
    check("T3.pc_sel2", 32'(pc_sel), 0);
    step(1, 9'h010, 2'b01, 32'h20, 0, 0, 0, 0, 9'h010);
    step(1, 9'h010, 2'b01, 32'h20, 1, 0, 0, 0, 9'h010);
    check("T3.pc_sel4", 32'(pc_sel), 1);
    idle(9'h010);
    check("T3.pred_saturated", 32'(pred_taken), 0);
    check("T3.mispred_cnt", mispred_cnt, 3);

    // T4 JALR target check
    step(1, 9'h040, 2'b11, 0, 32'h13, 0, 1, 32'h52, 9'h040);
    check("T4.pc_sel_match", 32'(pc_sel), 0);
    step(1, 9'h040, 2'b11, 0, 32'h13, 0, 1, 32'h50, 9'h040);
    check("T4.pc_sel_wrong", 32'(pc_sel), 1);
    check("T4.branch_pc", branch_pc, 32'h52);
    check("T4.pred_target", pred_target, 32'h52);
    step(1, 9'h100, 2'b10, 32'h40, 0, 0, 0, 0, 9'h100);
    check("T4.jal_branch_pc", branch_pc, 32'h140);
    idle(9'h100);
    check("T4.jal_pred", pred_target, 32'h140);
    idle(9'h050);
    check("T4.tag_miss", 32'(pred_taken), 0);

    // Non-transfer predicted taken: redirect to pc+4 and invalidate
    step(1, 9'h040, 2'b00, 0, 0, 0, 1, 32'h52, 9'h040);
    check("ALIAS.pc_sel", 32'(pc_sel), 1);
    check("ALIAS.branch_pc", branch_pc, 32'h44);
    idle(9'h040);
    check("ALIAS.pred_cleared", 32'(pred_taken), 0);

    // T5 halt has priority, no training, no count
    step(1, 9'h080, 2'b01, 32'h10, 1, 1, 0, 0, 9'h080);
    check("T5.pc_sel", 32'(pc_sel), 1);
    check("T5.branch_pc", branch_pc, 32'hFFFF_FFFF);
    idle(9'h080);
    check("T5.no_train", 32'(pred_taken), 0);
    check("T5.mispred_cnt", mispred_cnt, 6);
    step(0, 9'h000, 2'b00, 0, 0, 1, 0, 0, 9'h080);
    check("T5.halt_no_valid", 32'(pc_sel), 1);

    // T6 read/write collision, then asynchronous reset mid-stream
    step(1, 9'h0C0, 2'b10, 32'h8, 0, 0, 0, 0, 9'h0C0);
    check("T6.old_pred", 32'(pred_taken), 0);
    idle(9'h0C0);
    check("T6.new_pred", 32'(pred_taken), 1);
    check("T6.new_target", pred_target, 32'hC8);
    #1;
    rst_n = 1'b0;
    #1;
    check("T6.rst_pred", 32'(pred_taken), 0);
    check("T6.rst_cnt", mispred_cnt, 0);
    ex_valid = 1; ex_pc = 9'h020; ctrl_transfer = 2'b01; imm = 32'h8; ALU_result = 1;
    #1;
    check("T6.rst_comb_pc_sel", 32'(pc_sel), 1);
    check("T6.rst_comb_branch_pc", branch_pc, 32'h28);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(9'h0C0);
    check("T6.after_rst_pred", 32'(pred_taken), 0);

    // Mixed traffic over a small PC set, checked by the model only
    for (int k = 0; k < 60; k++) begin
      logic [8:0] pc;
      logic [31:0] alu;
      pc  = 9'({$urandom_range(0, 15), 2'b00});
      alu = $urandom_range(0, 7);
      step(1, pc, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 15)) << 2, alu, 0,
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, 9'({$urandom_range(0, 15), 2'b00}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
